matrix_input_collector: RTL and testbench
=========================================

Name: matrix_input_collector

Overview:
Serial-to-parallel matrix loader placed directly upstream of the transpose stage. It captures the dimensions m×n, then accepts m*n 8-bit elements one at a time over a valid/ready handshake in row-major order. It packs them into the 200-bit zero-padded 5×5 matrix bus and holds that result, with the dimensions, until the consumer acknowledges it.

Parameters:
MAX_DIM, 5, maximum rows and columns; the grid stride is always MAX_DIM.
ELEM_W, 8, element width in bits; the matrix bus width is MAX_DIM*MAX_DIM*ELEM_W = 200.
ELEM_MAX, 8'd255, clamp ceiling for elements; used only when the optional feature is compiled in.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
start  in  1  one-cycle request to begin a load with m_in/n_in.
m_in  in  3  row count, valid range 1..5.
n_in  in  3  column count, valid range 1..5.
elem_valid  in  1  element present on elem_data.
elem_data  in  ELEM_W  next element in row-major order.
elem_ready  out  1  collector accepts an element this cycle.
abort  in  1  cancel the load in progress.
out_ack  in  1  consumer has taken matrixA.
m_out  out  3  latched row count.
n_out  out  3  latched column count.
matrixA  out  200  element (i,j) at bits [(i*5+j)*8 +: 8]; unused cells are 0.
valid  out  1  matrixA, m_out and n_out are complete and stable.
busy  out  1  a load is in progress (LOAD state).
err_dim  out  1  one-cycle pulse when start carries invalid dimensions.
elem_count  out  5  number of elements accepted so far in this load, 0..25.

Behaviour:
- Reset (async assert, sync deassert into IDLE): matrixA=0, m_out=0, n_out=0, valid=0, busy=0, err_dim=0, elem_count=0, row=col=0.
- FSM has three states: IDLE, LOAD, DONE.
- IDLE: elem_ready=0.
  - start with dimensions valid (1..5 for both): latch m_out/n_out, clear matrixA to 0, zero row/col/elem_count, go to LOAD.
  - start with m_in or n_in equal to 0 or above 5: err_dim=1 for one cycle, stay in IDLE, leave outputs unchanged.
- LOAD: busy=1, elem_ready=1 (registered from state; not gated by abort).
  - On elem_valid&&elem_ready: write elem_data to cell (row,col) and increment elem_count.
  - col wraps from n_out-1 to 0, and row increments on the wrap.
  - Handshake on cell (m_out-1, n_out-1): go to DONE. valid=1 from the next cycle, so latency is 1 cycle after the last handshake.
  - elem_valid low: hold; gaps of any length are legal.
- DONE: valid=1, elem_ready=0, all outputs frozen.
  - out_ack: go to IDLE; valid=0 the following cycle. matrixA/m_out/n_out retain their values until the next accepted start.
- start asserted in LOAD or DONE is ignored, with no err_dim.
- abort in LOAD goes to IDLE, clears matrixA, zeros elem_count, and leaves valid=0.
- abort in the same cycle as an element handshake: abort wins and the element is discarded.
- abort in IDLE or DONE is ignored.
- out_ack outside DONE is ignored.
- Reset asserted mid-LOAD: immediate return to reset values; partial data is lost.
- No arithmetic overflow is possible: elem_count never exceeds m_out*n_out ≤ 25.

Optional Feature:
Macro MATRIX_ELEM_CLAMP_EN.
- Defined: an accepted element with elem_data > ELEM_MAX is stored as ELEM_MAX.
- Not defined: elements are stored verbatim and ELEM_MAX is unused.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package matrix_pkg holds MAX_DIM, ELEM_W, MAT_W=200, the state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2), and a cell-offset function (i*MAX_DIM+j)*ELEM_W. The transpose stage reuses the package.
- One natural sub-module, matrix_rc_counter: a row/column counter with load, clear, wrap at n and last-cell flag.

Test Plan:
- Load 2×3 with elements 1..6, one per cycle → bytes 0,1,2 = 1,2,3 and bytes 5,6,7 = 4,5,6; all other bytes 0; valid rises 1 cycle after the 6th handshake; elem_count=6.
- Load 5×5 with values 0x10..0x28 and random elem_valid gaps → byte k = 0x10+k; valid held until out_ack, then valid=0 the next cycle.
- start with m_in=0, n_in=3, then start with m_in=6, n_in=2 → err_dim pulses for 1 cycle each; state stays IDLE; busy=0.
- Load 3×3, abort after the 4th element while elem_valid=1 → that element is dropped; IDLE; matrixA=0; valid never asserts. A fresh 1×1 load of 0x7F then yields byte0 = 0x7F.
- Reset low mid-LOAD (after 2 of 4 elements) → all outputs zero immediately; start is ignored while reset is held.
- MATRIX_ELEM_CLAMP_EN defined with ELEM_MAX=100: load 1×2 with 200 and 50 → bytes 100 and 50. Without the macro, the same stimulus gives 200 and 50.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and geometry for the matrix loader and transpose stages.
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ELEM_W  = 8;
    localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int DIM_W   = 3;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cell_off(
        input logic [DIM_W-1:0] i,
        input logic [DIM_W-1:0] j
    );
        return (int'(i) * MAX_DIM + int'(j)) * ELEM_W;
    endfunction

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row/column walker over an m x n grid in row-major order.
module matrix_rc_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [DIM_W-1:0] m_i,
    input  logic [DIM_W-1:0] n_i,
    output logic [DIM_W-1:0] row_o,
    output logic [DIM_W-1:0] col_o,
    output logic             last_o
);

    logic [DIM_W-1:0] row_q;
    logic [DIM_W-1:0] col_q;
    logic             col_end;

    assign col_end = (col_q == n_i - 3'd1);
    assign last_o  = col_end && (row_q == m_i - 3'd1);
    assign row_o   = row_q;
    assign col_o   = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (inc_i) begin
            if (last_o) begin
                row_q <= '0;
                col_q <= '0;
            end else if (col_end) begin
                row_q <= row_q + 3'd1;
                col_q <= '0;
            end else begin
                col_q <= col_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_input_collector.sv
// Serial-to-parallel 5x5 matrix loader; MATRIX_ELEM_CLAMP_EN enables
// clamping of incoming elements to ELEM_MAX.
module matrix_input_collector
    import matrix_pkg::*;
#(
    parameter logic [ELEM_W-1:0] ELEM_MAX = 8'd255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  m_in,
    input  logic [DIM_W-1:0]  n_in,
    input  logic              elem_valid,
    input  logic [ELEM_W-1:0] elem_data,
    output logic              elem_ready,
    input  logic              abort,
    input  logic              out_ack,
    output logic [DIM_W-1:0]  m_out,
    output logic [DIM_W-1:0]  n_out,
    output logic [MAT_W-1:0]  matrixA,
    output logic              valid,
    output logic              busy,
    output logic              err_dim,
    output logic [CNT_W-1:0]  elem_count
);

    state_e             state_q;
    logic [DIM_W-1:0]   m_q;
    logic [DIM_W-1:0]   n_q;
    logic [MAT_W-1:0]   mat_q;
    logic               valid_q;
    logic               busy_q;
    logic               ready_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [DIM_W-1:0]   row;
    logic [DIM_W-1:0]   col;
    logic               last;
    logic               hs;
    logic               start_ok;
    logic               rc_clr;
    logic               rc_inc;
    logic [ELEM_W-1:0]  elem_st;

`ifdef MATRIX_ELEM_CLAMP_EN
    assign elem_st = (elem_data > ELEM_MAX) ? ELEM_MAX : elem_data;
`else
    logic unused_elem_max;
    assign unused_elem_max = ^ELEM_MAX;
    assign elem_st = elem_data;
`endif

    // ready_q is only ever set while in LOAD, so it doubles as the state gate
    assign hs       = elem_valid && ready_q;
    assign start_ok = start && dim_ok(m_in) && dim_ok(n_in);
    assign rc_clr   = ((state_q == IDLE) && start_ok)
                    || ((state_q == LOAD) && abort);
    assign rc_inc   = hs && !abort;

    matrix_rc_counter u_rc (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (rc_clr),
        .inc_i  (rc_inc),
        .m_i    (m_q),
        .n_i    (n_q),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            mat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        m_q     <= m_in;
                        n_q     <= n_in;
                        mat_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= LOAD;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        mat_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (hs) begin
                        mat_q[cell_off(row, col) +: ELEM_W] <= elem_st;
                        cnt_q <= cnt_q + 5'd1;
                        if (last) begin
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign elem_ready = ready_q;
    assign m_out      = m_q;
    assign n_out      = n_q;
    assign matrixA    = mat_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign err_dim    = err_q;
    assign elem_count = cnt_q;

endmodule

// File: tb/tb_matrix_input_collector.sv
// Directed self-checking bench for matrix_input_collector.
module tb_matrix_input_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   m_in;
    logic [2:0]   n_in;
    logic         elem_valid;
    logic [7:0]   elem_data;
    logic         elem_ready;
    logic         abort;
    logic         out_ack;
    logic [2:0]   m_out;
    logic [2:0]   n_out;
    logic [199:0] matrixA;
    logic         valid;
    logic         busy;
    logic         err_dim;
    logic [4:0]   elem_count;

    int checks = 0;
    int failures = 0;
    logic [199:0] exp_m;

    always #5 clk = ~clk;

    matrix_input_collector #(.ELEM_MAX(8'd100)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .m_in       (m_in),
        .n_in       (n_in),
        .elem_valid (elem_valid),
        .elem_data  (elem_data),
        .elem_ready (elem_ready),
        .abort      (abort),
        .out_ack    (out_ack),
        .m_out      (m_out),
        .n_out      (n_out),
        .matrixA    (matrixA),
        .valid      (valid),
        .busy       (busy),
        .err_dim    (err_dim),
        .elem_count (elem_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [199:0] obs,
                       input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] m, input logic [2:0] n);
        start = 1'b1;
        m_in  = m;
        n_in  = n;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        elem_valid = 1'b1;
        elem_data  = d;
        step();
        elem_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        m_in = 3'd0;
        n_in = 3'd0;
        elem_valid = 1'b0;
        elem_data = 8'd0;
        abort = 1'b0;
        out_ack = 1'b0;
        step();
        step();
        chk("rst_matrix", matrixA, '0);
        chk("rst_flags", {valid, busy, err_dim, elem_ready}, 4'b0000);
        chk("rst_dims", {m_out, n_out, elem_count}, 11'd0);
        rst_n = 1'b1;
        step();

        // 2x3 load, 1..6 back to back
        do_start(3'd2, 3'd3);
        chk("load_busy", {busy, elem_ready, valid}, 3'b110);
        chk("load_dims", {m_out, n_out}, {3'd2, 3'd3});
        for (int k = 1; k <= 5; k++) push(8'(k));
        chk("pre_last_valid", valid, 1'b0);
        chk("pre_last_cnt", elem_count, 5'd5);
        push(8'd6);
        exp_m = '0;
        exp_m[0*8 +: 8] = 8'd1;
        exp_m[1*8 +: 8] = 8'd2;
        exp_m[2*8 +: 8] = 8'd3;
        exp_m[5*8 +: 8] = 8'd4;
        exp_m[6*8 +: 8] = 8'd5;
        exp_m[7*8 +: 8] = 8'd6;
        chk("m2x3_valid", {valid, busy, elem_ready}, 3'b100);
        chk("m2x3_matrix", matrixA, exp_m);
        chk("m2x3_cnt", elem_count, 5'd6);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("ack_valid", valid, 1'b0);
        chk("ack_retain", matrixA, exp_m);

        // 5x5 with gaps, start/abort in DONE ignored
        do_start(3'd5, 3'd5);
        exp_m = '0;
        for (int k = 0; k < 25; k++) begin
            if (k % 3 == 1) step();
            push(8'(8'h10 + k));
            exp_m[k*8 +: 8] = 8'(8'h10 + k);
        end
        chk("m5x5_matrix", matrixA, exp_m);
        chk("m5x5_cnt", elem_count, 5'd25);
        start = 1'b1;
        m_in = 3'd2;
        n_in = 3'd2;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        chk("done_hold", {valid, busy, err_dim}, 3'b100);
        chk("done_dims", {m_out, n_out}, {3'd5, 3'd5});
        chk("done_matrix", matrixA, exp_m);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("m5x5_ack", valid, 1'b0);

        // invalid dimensions
        do_start(3'd0, 3'd3);
        chk("err0_pulse", {err_dim, busy, elem_ready}, 3'b100);
        step();
        chk("err0_clear", err_dim, 1'b0);
        do_start(3'd6, 3'd2);
        chk("err6_pulse", {err_dim, busy}, 2'b10);
        step();
        chk("err6_clear", {err_dim, busy}, 2'b00);
        chk("err_dims_kept", {m_out, n_out}, {3'd5, 3'd5});

        // 3x3 with abort colliding with an element
        do_start(3'd3, 3'd3);
        for (int k = 1; k <= 4; k++) push(8'(8'hA0 + k));
        chk("abort_pre_cnt", elem_count, 5'd4);
        elem_valid = 1'b1;
        elem_data = 8'hEE;
        abort = 1'b1;
        step();
        elem_valid = 1'b0;
        abort = 1'b0;
        chk("abort_flags", {valid, busy, elem_ready}, 3'b000);
        chk("abort_matrix", matrixA, '0);
        chk("abort_cnt", elem_count, 5'd0);
        step();
        chk("abort_no_valid", valid, 1'b0);
        do_start(3'd1, 3'd1);
        push(8'h7F);
        exp_m = '0;
        exp_m[7:0] = 8'h7F;
        chk("m1x1_matrix", matrixA, exp_m);
        chk("m1x1_valid", {valid, m_out, n_out}, {1'b1, 3'd1, 3'd1});
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;

        // reset in the middle of a load
        do_start(3'd2, 3'd2);
        push(8'h11);
        push(8'h22);
        chk("mid_cnt", elem_count, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_matrix", matrixA, '0);
        chk("rstmid_flags", {valid, busy, elem_ready, elem_count}, 8'd0);
        chk("rstmid_dims", {m_out, n_out}, 6'd0);
        step();
        do_start(3'd2, 3'd2);
        step();
        chk("rst_held_start", {busy, elem_ready, m_out}, 5'd0);
        rst_n = 1'b1;
        step();

        // clamp behaviour depends on build
        do_start(3'd1, 3'd2);
        push(8'd200);
        push(8'd50);
        exp_m = '0;
`ifdef MATRIX_ELEM_CLAMP_EN
        exp_m[7:0] = 8'd100;
`else
        exp_m[7:0] = 8'd200;
`endif
        exp_m[15:8] = 8'd50;
        chk("clamp_matrix", matrixA, exp_m);
        chk("clamp_valid", valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
